// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: fetch buffer plus single-issue sequencer for the RV32
// decoder; collects decoded fields and dispatches one bundle to execute.
module decode_issue_ctrl #(
  parameter int BUS_WIDTH      = 32,
  parameter int OPCODE_WIDTH   = 11,
  parameter int ADDR_WIDTH     = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_valid,
  input  logic [BUS_WIDTH-1:0]    fetch_instr,
  output logic                    fetch_ready,
  output logic                    instr_valid,
  output logic [BUS_WIDTH-1:0]    instr,
  output logic                    next_instr,
  output logic [OPCODE_WIDTH-1:0] op_done,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [BUS_WIDTH-1:0]    imme_value,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [ADDR_WIDTH-1:0]   rs_addr,
  input  logic                    rs_addr_sel,
  input  logic                    rs_addr_valid,
  output logic                    ex_start,
  output logic [OPCODE_WIDTH-1:0] ex_opcode,
  output logic [ADDR_WIDTH-1:0]   ex_rd_addr,
  output logic [ADDR_WIDTH-1:0]   ex_rs1_addr,
  output logic [ADDR_WIDTH-1:0]   ex_rs2_addr,
  output logic [BUS_WIDTH-1:0]    ex_imm,
  input  logic                    ex_done,
  output logic                    busy,
  output logic                    illegal_instr,
  output logic                    timeout_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, ISSUE, DECODE, COLLECT,
    DISPATCH, WAIT_EX, RETIRE, ABORT
  } state_t;

  state_t state, state_nx;

  logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt, cnt_nx;
  logic                 rdy_q, push, pop;

  // rdy_q keeps fetch_ready low during reset and for the reset cycle itself
  assign fetch_ready = rdy_q && (cnt != FULL);
  assign push        = fetch_valid && fetch_ready;
  assign pop         = (state == RETIRE) || (state == ABORT);
  assign instr       = (cnt != '0) ? mem[rd_ptr] : '0;

  always_comb begin
    cnt_nx = cnt;
    if (push && !pop)      cnt_nx = cnt + 1'b1;
    else if (!push && pop) cnt_nx = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      cnt   <= cnt_nx;
      if (push) begin
        mem[wr_ptr] <= fetch_instr;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [6:0] maj;
  logic [1:0] nsrc;
  logic       legal;

  assign maj = opcode[6:0];

  always_comb begin
    nsrc  = 2'd0;
    legal = 1'b1;
    unique case (1'b1)
      (maj == 7'b0110011) || (maj == 7'b0100011) ||
      (maj == 7'b1100011): nsrc = 2'd2;
      (maj == 7'b0010011) || (maj == 7'b0000011) ||
      (maj == 7'b1100111): nsrc = 2'd1;
      (maj == 7'b0110111) || (maj == 7'b0010111) ||
      (maj == 7'b1101111): nsrc = 2'd0;
      default:             legal = 1'b0;
    endcase
  end

  logic [OPCODE_WIDTH-1:0] op_q;
  logic [ADDR_WIDTH-1:0]   rd_q, rs1_q, rs2_q;
  logic [BUS_WIDTH-1:0]    imm_q;
  logic [1:0]              nsrc_q;
  logic                    seen1, seen2, ill_q;
  logic [TW-1:0]           tmr, tmr_inc;
  logic                    s1_nx, s2_nx, srcs_ok;

  assign tmr_inc = tmr + 1'b1;
  assign s1_nx   = seen1 || (rs_addr_valid && !rs_addr_sel);
  assign s2_nx   = seen2 || (rs_addr_valid && rs_addr_sel);
  assign srcs_ok = s1_nx && ((nsrc_q == 2'd1) || s2_nx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      nsrc_q <= '0;
      seen1  <= 1'b0;
      seen2  <= 1'b0;
      ill_q  <= 1'b0;
      tmr    <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) begin
        op_q   <= opcode;
        rd_q   <= rd_addr;
        imm_q  <= imme_value;
        rs1_q  <= '0;
        rs2_q  <= '0;
        nsrc_q <= nsrc;
        seen1  <= 1'b0;
        seen2  <= 1'b0;
        ill_q  <= !legal;
        tmr    <= '0;
      end
      if (state == COLLECT) begin
        tmr <= tmr_inc;
        if (rs_addr_valid && !rs_addr_sel) begin
          rs1_q <= rs_addr;
          seen1 <= 1'b1;
        end
        // rs2 only matters for two-source formats
        if (rs_addr_valid && rs_addr_sel && nsrc_q == 2'd2) begin
          rs2_q <= rs_addr;
          seen2 <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (cnt != '0 || push) state_nx = ISSUE;
      ISSUE:    state_nx = DECODE;
      DECODE: begin
        if (!legal)              state_nx = ABORT;
        else if (nsrc == 2'd0)   state_nx = DISPATCH;
        else                     state_nx = COLLECT;
      end
      COLLECT: begin
        if (srcs_ok)             state_nx = DISPATCH;
        else if (tmr_inc == TMAX) state_nx = ABORT;
      end
      DISPATCH: state_nx = WAIT_EX;
      WAIT_EX:  if (ex_done) state_nx = RETIRE;
      RETIRE, ABORT:
        state_nx = (cnt_nx != '0) ? ISSUE : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign instr_valid   = (state == ISSUE);
  assign ex_start      = (state == DISPATCH);
  assign next_instr    = pop;
  assign op_done       = (state == RETIRE) ? op_q : '0;
  assign illegal_instr = (state == ABORT) && ill_q;
  assign timeout_err   = (state == ABORT) && !ill_q;
  assign busy          = (state != IDLE);
  assign ex_opcode     = op_q;
  assign ex_rd_addr    = rd_q;
  assign ex_rs1_addr   = rs1_q;
  assign ex_rs2_addr   = rs2_q;
  assign ex_imm        = imm_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: bench acts as fetch, decoder and execute unit and
// checks every handshake against a transaction-level model of the sequencer.
module tb_decode_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int TO    = 255;

  logic        clk, rst_n;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_instr, instr, imme_value, ex_imm;
  logic        instr_valid, next_instr, ex_start, ex_done;
  logic [10:0] op_done, opcode, ex_opcode;
  logic [4:0]  rd_addr, rs_addr, ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
  logic        rs_addr_sel, rs_addr_valid;
  logic        busy, illegal_instr, timeout_err;

  decode_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr(instr),
    .next_instr(next_instr), .op_done(op_done),
    .opcode(opcode), .imme_value(imme_value), .rd_addr(rd_addr),
    .rs_addr(rs_addr), .rs_addr_sel(rs_addr_sel),
    .rs_addr_valid(rs_addr_valid),
    .ex_start(ex_start), .ex_opcode(ex_opcode),
    .ex_rd_addr(ex_rd_addr), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_imm(ex_imm),
    .ex_done(ex_done), .busy(busy),
    .illegal_instr(illegal_instr), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_chk = 0, n_err = 0, n_cyc = 0;
  logic [31:0] q[$];
  logic [31:0] src[$];
  logic [31:0] push_word;
  bit          push_pend = 0, pop_pend = 0, fetch_on = 0;
  int          rate = 100;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int src_count(input logic [6:0] m);
    case (m)
      7'h33, 7'h23, 7'h63: return 2;
      7'h13, 7'h03, 7'h67: return 1;
      7'h37, 7'h17, 7'h6F: return 0;
      default:             return -1;
    endcase
  endfunction

  function automatic logic [10:0] rand_opc(input bit allow_ill);
    logic [6:0] majs [9];
    logic [6:0] m;
    majs = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03,
             7'h67, 7'h37, 7'h17, 7'h6F};
    if (allow_ill && $urandom_range(0, 9) == 0) begin
      m = 7'($urandom);
      while (src_count(m) >= 0) m = 7'($urandom);
    end else begin
      m = majs[$urandom_range(0, 8)];
    end
    return {4'($urandom), m};
  endfunction

  // one clock: retire model events of the last edge, check fetch_ready,
  // then drive the fetch side for the coming edge
  task automatic cyc();
    @(posedge clk);
    #1;
    n_cyc++;
    if (n_cyc > 60000) begin
      $display("FAIL watchdog: got %0d cycles expected < 60000", n_cyc);
      $fatal(1);
    end
    if (!rst_n) begin
      q.delete();
      push_pend = 0;
      pop_pend  = 0;
    end else begin
      if (pop_pend) void'(q.pop_front());
      if (push_pend) q.push_back(push_word);
      pop_pend  = 0;
      push_pend = 0;
    end
    chk("fetch_ready", fetch_ready, rst_n ? (q.size() < DEPTH) : 1'b0);
    if (rst_n && fetch_on && src.size() > 0 &&
        $urandom_range(0, 99) < rate) begin
      fetch_valid = 1'b1;
      fetch_instr = src[0];
      if (fetch_ready) begin
        push_pend = 1;
        push_word = src.pop_front();
      end
    end else begin
      fetch_valid = 1'b0;
      fetch_instr = $urandom;
    end
  endtask

  task automatic do_instr(input logic [10:0] opc, input logic [4:0] rd,
                          input logic [31:0] imm, input int nwait,
                          input bit to_mode, input bit rst_mode,
                          input bit dir_src, input int issue_lat);
    int          waited = 0, ns, k = 0, bad = 0;
    logic [4:0]  r1 = '0, r2 = '0;
    bit          s1 = 0, s2 = 0;
    logic [31:0] w;
    while (!instr_valid && waited < 400) begin
      cyc();
      waited++;
    end
    chk("issue_seen", instr_valid, 1'b1);
    if (!instr_valid) return;
    if (issue_lat >= 0) chk("issue_lat", waited, issue_lat);
    w = (q.size() > 0) ? q[0] : 32'hDEAD_BEEF;
    chk("instr", instr, w);
    chk("busy", busy, 1'b1);
    opcode     = opc;
    rd_addr    = rd;
    imme_value = imm;
    ex_done    = 1'($urandom);
    cyc();
    chk("issue_once", instr_valid, 1'b0);
    ns = src_count(opc[6:0]);
    cyc();
    opcode     = 11'($urandom);
    rd_addr    = 5'($urandom);
    imme_value = $urandom;
    if (ns < 0) begin
      chk("illegal", illegal_instr, 1'b1);
      chk("ill_next", next_instr, 1'b1);
      chk("ill_opdone", op_done, 0);
      chk("ill_start", ex_start, 1'b0);
      pop_pend = 1;
      ex_done  = 1'b0;
      cyc();
      chk("ill_once", {illegal_instr, next_instr}, 0);
      return;
    end
    if (ns > 0 && to_mode) begin
      for (int i = 0; i < TO; i++) begin
        if (timeout_err || ex_start || next_instr) bad++;
        cyc();
      end
      chk("to_early", bad, 0);
      chk("timeout", timeout_err, 1'b1);
      chk("to_next", next_instr, 1'b1);
      chk("to_start", ex_start, 1'b0);
      pop_pend = 1;
      ex_done  = 1'b0;
      cyc();
      chk("to_once", timeout_err, 1'b0);
      return;
    end
    while (ns > 0 && !(s1 && (ns == 1 || s2)) && k < 60) begin
      if (ex_start || timeout_err) bad++;
      if (dir_src) begin
        rs_addr_valid = 1'b1;
        rs_addr_sel   = (k == 1);
        rs_addr       = (k == 0) ? 5'd1 : 5'd2;
      end else begin
        rs_addr_valid = ($urandom_range(0, 3) != 0);
        rs_addr_sel   = 1'($urandom);
        rs_addr       = 5'($urandom);
      end
      ex_done = 1'($urandom);
      if (rs_addr_valid && !rs_addr_sel) begin
        r1 = rs_addr;
        s1 = 1;
      end else if (rs_addr_valid && ns == 2) begin
        r2 = rs_addr;
        s2 = 1;
      end
      cyc();
      k++;
    end
    rs_addr_valid = 1'b0;
    chk("collect_quiet", bad, 0);
    chk("ex_start", ex_start, 1'b1);
    chk("ex_opcode", ex_opcode, opc);
    chk("ex_rd", ex_rd_addr, rd);
    chk("ex_rs", {ex_rs1_addr, ex_rs2_addr}, {r1, r2});
    chk("ex_imm", ex_imm, imm);
    ex_done = 1'b0;
    cyc();
    chk("start_once", ex_start, 1'b0);
    if (rst_mode) begin
      fetch_on    = 0;
      fetch_valid = 1'b0;
      push_pend   = 0;
      src.delete();
      rst_n = 1'b0;
      cyc();
      chk("rst_ctl", {fetch_ready, instr_valid, next_instr, ex_start,
                      busy, illegal_instr, timeout_err}, 0);
      chk("rst_instr", instr, 0);
      chk("rst_opdone", op_done, 0);
      chk("rst_ex", {ex_opcode, ex_rd_addr, ex_rs1_addr,
                     ex_rs2_addr, ex_imm}, 0);
      rst_n   = 1'b1;
      ex_done = 1'b1;
      cyc();
      ex_done = 1'b0;
      chk("post_rst", {busy, next_instr, op_done}, 0);
      return;
    end
    for (int i = 0; i < nwait; i++) begin
      if (next_instr || op_done != 0 || !busy) bad++;
      cyc();
    end
    chk("wait_quiet", bad, 0);
    ex_done = 1'b1;
    cyc();
    ex_done = 1'b0;
    chk("op_done", op_done, opc);
    chk("retire_next", next_instr, 1'b1);
    pop_pend = 1;
    cyc();
    chk("retire_once", {next_instr, op_done}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b0; fetch_instr = '0;
    opcode = '0; imme_value = '0; rd_addr = '0;
    rs_addr = '0; rs_addr_sel = 1'b0; rs_addr_valid = 1'b0;
    ex_done = 1'b0;
    cyc();
    cyc();
    chk("reset_ctl", {instr_valid, next_instr, ex_start, busy,
                      illegal_instr, timeout_err}, 0);
    chk("reset_data", {op_done, ex_opcode, ex_imm}, 0);
    rst_n = 1'b1;
    cyc();
    chk("idle_busy", busy, 1'b0);

    // add x3,x1,x2
    fetch_on = 1;
    src.push_back(32'h002081B3);
    do_instr(11'h033, 5'd3, 32'h0, 2, 0, 0, 1, -1);

    // lui x5: three-cycle push-to-dispatch path
    src.push_back(32'h123452B7);
    cyc();
    fetch_on = 0;
    do_instr(11'h037, 5'd5, 32'h12345000, 1, 0, 0, 0, 1);

    // fill the buffer while execute stalls, then drain with wrap
    fetch_on = 1;
    for (int i = 0; i < 10; i++) src.push_back($urandom);
    do_instr(rand_opc(0), 5'($urandom), $urandom, 12, 0, 0, 0, -1);
    for (int i = 0; i < 9; i++)
      do_instr(rand_opc(0), 5'($urandom), $urandom,
               $urandom_range(0, 4), 0, 0, 0, -1);

    // illegal opcode followed by a queued instruction
    src.push_back($urandom);
    src.push_back($urandom);
    do_instr(11'h07F, 5'd7, 32'h1, 0, 0, 0, 0, -1);
    do_instr(rand_opc(0), 5'($urandom), $urandom, 1, 0, 0, 0, -1);

    // I-type that never sees its source
    src.push_back($urandom);
    src.push_back($urandom);
    do_instr(11'h013, 5'd9, 32'h5, 0, 1, 0, 0, -1);
    do_instr(rand_opc(0), 5'($urandom), $urandom, 1, 0, 0, 0, -1);

    // reset while waiting on execute, then a fresh instruction
    src.push_back($urandom);
    src.push_back($urandom);
    do_instr(11'h033, 5'd4, 32'h0, 0, 0, 0, 0, -1);
    do_instr(11'h063, 5'd6, 32'h40, 0, 0, 1, 0, -1);
    fetch_on = 1;
    src.push_back(32'h123452B7);
    do_instr(11'h037, 5'd5, 32'h12345000, 2, 0, 0, 0, -1);

    // random mix with bursty fetch
    rate = 40;
    for (int i = 0; i < 40; i++) src.push_back($urandom);
    for (int i = 0; i < 40; i++)
      do_instr(rand_opc(1), 5'($urandom), $urandom,
               $urandom_range(0, 6), 0, 0, 0, -1);

    for (int i = 0; i < 4; i++) cyc();
    chk("end_idle", {busy, instr_valid, ex_start, next_instr}, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
